exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 64 ++++++
 rtl/exc_ctrl_int_sync.sv | 28 ++
 rtl/exc_ctrl.sv | 121 ++++++++++++
 tb/tb_exc_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: ExcCode values,
// mem_exc_flags bit positions, FSM encoding and the cause decoder.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int FLAG_ADEL_FETCH = 0;
  localparam int FLAG_RI         = 1;
  localparam int FLAG_SYS        = 2;
  localparam int FLAG_BP         = 3;
  localparam int FLAG_OV         = 4;
  localparam int FLAG_ADEL_DATA  = 5;
  localparam int FLAG_ADES       = 6;
  localparam int FLAG_ERET       = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic       is_eret;     // no exception present, only an eret
    logic       addr_err;    // AdEL/AdES: BadVAddr must be written
    logic       from_fetch;  // address error came from the fetch, use the PC
    logic [4:0] code;
  } cause_t;

  // Fixed-priority cause selection; eret is only reported when nothing else is.
  function automatic cause_t decode_cause(input logic int_pend, input logic [7:0] flags);
    cause_t c;
    c = '0;
    if (int_pend) begin
      c.code = EXC_INT;
    end else if (flags[FLAG_ADEL_FETCH]) begin
      c.code = EXC_ADEL;
      c.addr_err = 1'b1;
      c.from_fetch = 1'b1;
    end else if (flags[FLAG_RI]) begin
      c.code = EXC_RI;
    end else if (flags[FLAG_SYS]) begin
      c.code = EXC_SYS;
    end else if (flags[FLAG_BP]) begin
      c.code = EXC_BP;
    end else if (flags[FLAG_OV]) begin
      c.code = EXC_OV;
    end else if (flags[FLAG_ADEL_DATA]) begin
      c.code = EXC_ADEL;
      c.addr_err = 1'b1;
    end else if (flags[FLAG_ADES]) begin
      c.code = EXC_ADES;
      c.addr_err = 1'b1;
    end else begin
      c.is_eret = flags[FLAG_ERET];
    end
    return c;
  endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchronizer for the asynchronous interrupt lines.
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Each line gets its own first/second flop pair.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta[gi] <= 1'b0;
          dout[gi] <= 1'b0;
        end else begin
          meta[gi] <= din[gi];
          dout[gi] <= meta[gi];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: picks the highest-priority cause,
// issues one-cycle CP0 commit strobes and a PC redirect, then holds
// the pipeline flush for FLUSH_CYCLES cycles.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        pipe_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_is_bd,
  input  logic [7:0]  mem_exc_flags,
  input  logic [31:0] mem_badvaddr,
  input  logic [5:0]  hw_int,
  input  logic        cp0_is_ie,
  input  logic        cp0_is_exl,
  input  logic [7:0]  cp0_int_mask,
  input  logic [1:0]  cp0_soft_int,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  cp0_hw_int,
  output logic        cp0_is_exception,
  output logic        cp0_is_excep_return,
  output logic        cp0_we_badvaddr,
  output logic        cp0_is_bd,
  output logic [4:0]  cp0_exc_code,
  output logic [31:0] cp0_exc_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  // The counter is loaded with one less than the flush length so that
  // the FLUSH state lasts exactly FLUSH_CYCLES cycles.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [5:0]  hw_int_s;
  logic        int_pend;
  logic        take;
  cause_t      cause;
  logic [31:0] epc_cand;

  int_sync #(.WIDTH(6)) u_int_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (hw_int),
    .dout (hw_int_s)
  );

  assign cp0_hw_int = hw_int_s;
  assign int_pend   = cp0_is_ie & ~cp0_is_exl &
                      (|(cp0_int_mask & {hw_int_s, cp0_soft_int}));
  assign take       = (state == ST_IDLE) & mem_valid & ~pipe_stall &
                      (int_pend | (|mem_exc_flags));
  assign cause      = decode_cause(int_pend, mem_exc_flags);
  // A delay-slot instruction restarts at its branch, one word earlier.
  assign epc_cand   = mem_is_bd ? (mem_pc - 32'd4) : mem_pc;

  // Take/flush FSM with all CP0 and redirect outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= ST_IDLE;
      cnt                 <= 3'd0;
      cp0_is_exception    <= 1'b0;
      cp0_is_excep_return <= 1'b0;
      cp0_we_badvaddr     <= 1'b0;
      cp0_is_bd           <= 1'b0;
      cp0_exc_code        <= 5'd0;
      cp0_exc_pc          <= 32'd0;
      cp0_badvaddr        <= 32'd0;
      flush               <= 1'b0;
      redirect_valid      <= 1'b0;
      redirect_pc         <= 32'd0;
    end else begin
      cp0_is_exception    <= 1'b0;
      cp0_is_excep_return <= 1'b0;
      cp0_we_badvaddr     <= 1'b0;
      redirect_valid      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            state          <= ST_FLUSH;
            cnt            <= CNT_LOAD;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            if (cause.is_eret) begin
              cp0_is_excep_return <= 1'b1;
              redirect_pc         <= cp0_epc;
            end else begin
              cp0_is_exception <= 1'b1;
              cp0_exc_code     <= cause.code;
              cp0_exc_pc       <= epc_cand;
              cp0_is_bd        <= mem_is_bd;
              redirect_pc      <= EXC_VECTOR;
              if (cause.addr_err) begin
                cp0_we_badvaddr <= 1'b1;
                cp0_badvaddr    <= cause.from_fetch ? mem_pc : mem_badvaddr;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (cnt == 3'd0) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a cycle-level reference model.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0, pipe_stall = 1'b0, mem_is_bd = 1'b0;
  logic [31:0] mem_pc = '0, mem_badvaddr = '0, cp0_epc = '0;
  logic [7:0]  mem_exc_flags = '0, cp0_int_mask = '0;
  logic [5:0]  hw_int = '0;
  logic        cp0_is_ie = 1'b0, cp0_is_exl = 1'b0;
  logic [1:0]  cp0_soft_int = '0;

  logic [5:0]  cp0_hw_int;
  logic        cp0_is_exception, cp0_is_excep_return, cp0_we_badvaddr, cp0_is_bd;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_exc_pc, cp0_badvaddr, redirect_pc;
  logic        flush, redirect_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [5:0]  hd1, hd2;          // interrupt inputs one and two cycles ago
  int          flush_left;        // flush cycles still owed
  logic        known;             // code/pc/bd expectations are defined
  logic [5:0]  e_hw;
  logic        e_exc, e_eret, e_we, e_rv, e_flush, e_bd;
  logic [4:0]  e_code;
  logic [31:0] e_epc, e_bva, e_rpc;
  int unsigned code_of_flag [0:6] = '{4, 10, 8, 9, 12, 4, 5};

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .pipe_stall(pipe_stall),
    .mem_pc(mem_pc), .mem_is_bd(mem_is_bd), .mem_exc_flags(mem_exc_flags),
    .mem_badvaddr(mem_badvaddr), .hw_int(hw_int), .cp0_is_ie(cp0_is_ie),
    .cp0_is_exl(cp0_is_exl), .cp0_int_mask(cp0_int_mask),
    .cp0_soft_int(cp0_soft_int), .cp0_epc(cp0_epc), .cp0_hw_int(cp0_hw_int),
    .cp0_is_exception(cp0_is_exception), .cp0_is_excep_return(cp0_is_excep_return),
    .cp0_we_badvaddr(cp0_we_badvaddr), .cp0_is_bd(cp0_is_bd),
    .cp0_exc_code(cp0_exc_code), .cp0_exc_pc(cp0_exc_pc),
    .cp0_badvaddr(cp0_badvaddr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hd1 = '0; hd2 = '0; flush_left = 0; known = 1'b1;
    e_hw = '0; e_exc = 0; e_eret = 0; e_we = 0; e_rv = 0; e_flush = 0; e_bd = 0;
    e_code = '0; e_epc = '0; e_bva = '0; e_rpc = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic pend, take;
    int   first;
    pend  = cp0_is_ie && !cp0_is_exl && ((cp0_int_mask & {hd2, cp0_soft_int}) != 8'd0);
    take  = (flush_left == 0) && mem_valid && !pipe_stall && (pend || mem_exc_flags != 8'd0);
    e_hw  = hd1;
    hd2   = hd1;
    hd1   = hw_int;
    e_exc = 0; e_eret = 0; e_we = 0; e_rv = 0;
    if (take) begin
      first = -1;
      for (int i = 6; i >= 0; i--) if (mem_exc_flags[i]) first = i;
      e_rv = 1;
      flush_left = FC;
      if (pend || first >= 0) begin
        e_exc  = 1;
        known  = 1;
        e_code = pend ? 5'd0 : 5'(code_of_flag[first]);
        e_epc  = mem_is_bd ? mem_pc - 32'd4 : mem_pc;
        e_bd   = mem_is_bd;
        e_rpc  = VEC;
        if (!pend && (first == 0 || first == 5 || first == 6)) begin
          e_we  = 1;
          e_bva = (first == 0) ? mem_pc : mem_badvaddr;
        end
      end else begin
        e_eret = 1;
        known  = 0;
        e_rpc  = cp0_epc;
      end
    end else if (flush_left > 0) begin
      flush_left--;
    end
    e_flush = (flush_left > 0);
  endtask

  task automatic compare_all();
    chk("hw_int", 32'(cp0_hw_int), 32'(e_hw));
    chk("is_exception", 32'(cp0_is_exception), 32'(e_exc));
    chk("is_excep_return", 32'(cp0_is_excep_return), 32'(e_eret));
    chk("we_badvaddr", 32'(cp0_we_badvaddr), 32'(e_we));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("flush", 32'(flush), 32'(e_flush));
    if (known) begin
      chk("exc_code", 32'(cp0_exc_code), 32'(e_code));
      chk("exc_pc", cp0_exc_pc, e_epc);
      chk("is_bd", 32'(cp0_is_bd), 32'(e_bd));
    end
    if (e_we) chk("badvaddr", cp0_badvaddr, e_bva);
    if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero"}, {cp0_hw_int, cp0_is_exception, cp0_is_excep_return,
        cp0_we_badvaddr, cp0_is_bd, cp0_exc_code, flush, redirect_valid, 11'd0}, 32'd0);
    chk({tag, "_excpc"}, cp0_exc_pc, 32'd0);
    chk({tag, "_bva"}, cp0_badvaddr, 32'd0);
    chk({tag, "_rpc"}, redirect_pc, 32'd0);
  endtask

  task automatic quiet();
    mem_valid = 0; pipe_stall = 0; mem_exc_flags = '0; mem_is_bd = 0;
    cp0_is_ie = 0; cp0_is_exl = 0; hw_int = '0;
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1'b0;
    #1 chk_all_zero(tag);
    model_reset();
    @(negedge clk) rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) tick();

    // Syscall, not in a delay slot
    mem_valid = 1; mem_pc = 32'h8000_0100; mem_exc_flags = 8'h04;
    tick();
    chk("sys_exc", 32'(cp0_is_exception), 32'd1);
    chk("sys_code", 32'(cp0_exc_code), 32'd8);
    chk("sys_pc", cp0_exc_pc, 32'h8000_0100);
    chk("sys_rpc", redirect_pc, 32'hBFC0_0380);
    chk("sys_flush1", 32'(flush), 32'd1);
    quiet();
    tick();
    chk("sys_flush2", 32'(flush), 32'd1);
    tick();
    chk("sys_flush_end", 32'(flush), 32'd0);

    // AdEL on a data access in a delay slot
    mem_valid = 1; mem_is_bd = 1; mem_pc = 32'h8000_0204;
    mem_badvaddr = 32'h0000_0003; mem_exc_flags = 8'h20;
    tick();
    chk("adel_code", 32'(cp0_exc_code), 32'd4);
    chk("adel_bd", 32'(cp0_is_bd), 32'd1);
    chk("adel_pc", cp0_exc_pc, 32'h8000_0200);
    chk("adel_we", 32'(cp0_we_badvaddr), 32'd1);
    chk("adel_bva", cp0_badvaddr, 32'h0000_0003);
    quiet();
    repeat (3) tick();

    // Interrupt on hw_int[0] outranks RI once synchronized
    cp0_is_ie = 1; cp0_int_mask = 8'h04; hw_int = 6'h01; mem_pc = 32'h8000_0300;
    tick();
    tick();
    mem_valid = 1; mem_exc_flags = 8'h02;
    tick();
    chk("int_exc", 32'(cp0_is_exception), 32'd1);
    chk("int_code", 32'(cp0_exc_code), 32'd0);
    quiet();
    repeat (3) tick();

    // eret
    mem_valid = 1; mem_exc_flags = 8'h80; cp0_epc = 32'h8000_1000;
    tick();
    chk("eret_ret", 32'(cp0_is_excep_return), 32'd1);
    chk("eret_exc", 32'(cp0_is_exception), 32'd0);
    chk("eret_rpc", redirect_pc, 32'h8000_1000);
    quiet();
    repeat (3) tick();

    // Ov during FLUSH ignored, stalled Bp waits, reset aborts a flush
    mem_valid = 1; mem_pc = 32'h8000_0400; mem_exc_flags = 8'h04;
    tick();
    mem_exc_flags = 8'h10;
    tick();
    chk("ov_in_flush", 32'(cp0_is_exception), 32'd0);
    mem_exc_flags = 8'h00;
    tick();
    mem_exc_flags = 8'h08; pipe_stall = 1;
    tick();
    chk("bp_stall1", 32'(cp0_is_exception), 32'd0);
    tick();
    chk("bp_stall2", 32'(cp0_is_exception), 32'd0);
    pipe_stall = 0;
    tick();
    chk("bp_exc", 32'(cp0_is_exception), 32'd1);
    chk("bp_code", 32'(cp0_exc_code), 32'd9);
    mem_exc_flags = 8'h00;
    mid_reset("rst_flush");
    mem_exc_flags = 8'h04; mem_pc = 32'h8000_0500;
    tick();
    chk("resume_exc", 32'(cp0_is_exception), 32'd1);
    quiet();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      mem_valid  = ($urandom % 4) != 0;
      pipe_stall = ($urandom % 5) == 0;
      r = $urandom % 8;
      if (r < 5) mem_exc_flags = 8'h00;
      else if (r == 5) mem_exc_flags = 8'(1 << ($urandom % 8));
      else mem_exc_flags = 8'($urandom);
      mem_pc = $urandom;
      mem_pc[1:0] = 2'b00;
      mem_is_bd = 1'($urandom);
      mem_badvaddr = $urandom;
      cp0_epc = $urandom;
      if ($urandom % 16 == 0) hw_int = 6'($urandom);
      if ($urandom % 8 == 0) begin
        cp0_is_ie = 1'($urandom);
        cp0_is_exl = ($urandom % 4) == 0;
        cp0_int_mask = 8'($urandom);
        cp0_soft_int = 2'($urandom);
      end
      if (i == 200) mid_reset("rst_rand");
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
